// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle sequencer for the MIPS HI/LO multiply/divide unit.
// It owns HI and LO. Multiplies complete after MUL_LAT busy cycles. Divides run
// 32 restoring iterations and then one sign-fix cycle. MTHI and MTLO complete
// in a single cycle. stall holds the pipeline while a dependent instruction
// waits for the unit.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start, op       request from EXE (op encodings below)
//   a, b            rs / rt operands
//   rd_hilo         EXE instruction is MFHI/MFLO
//   flush           cancel in-flight op; has priority over start
//   busy, stall     unit busy; pipeline hold = busy & (start | rd_hilo)
//   hi, lo          architectural HI / LO registers
//   res, res_valid  MUL result and its one-cycle valid pulse
module muldiv_ctrl #(
   parameter int MUL_LAT = 4  // 1..15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        rd_hilo,
   input  logic        flush,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] res,
   output logic        res_valid
);

   localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV   = 4'd3,
                          OP_DIVU  = 4'd4, OP_MADD  = 4'd5, OP_MADDU = 4'd6,
                          OP_MSUB  = 4'd7, OP_MSUBU = 4'd8, OP_MTHI  = 4'd9,
                          OP_MTLO  = 4'd10, OP_MUL  = 4'd11;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [4:0]  iter_q, iter_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] opa_q, opa_d;   // raw a (multiply operand; divide-by-zero HI value)
   logic [31:0] opb_q, opb_d;   // raw b for multiply, |b| for divide
   logic [63:0] rq_q, rq_d;     // {remainder, quotient} shift register
   logic        qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d, res_q, res_d;
   logic        res_valid_q, res_valid_d;

   logic        signed_op, sdiv, legal;
   logic [63:0] ext_a, ext_b, prod, acc;
   logic [32:0] diff;
   logic [63:0] step_rq;
   logic [31:0] quo_fix, rem_fix;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      iter_d      = iter_q;
      op_d        = op_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      rq_d        = rq_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      dz_d        = dz_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      res_d       = res_q;
      res_valid_d = 1'b0;

      legal = (op >= OP_MULT) && (op <= OP_MUL);
      sdiv  = (op == OP_DIV);

      // Low 64 bits of the product of 64-bit extended operands equal the
      // two's-complement (or unsigned) 64-bit product.
      signed_op = (op_q == OP_MULT) || (op_q == OP_MADD) ||
                  (op_q == OP_MSUB) || (op_q == OP_MUL);
      ext_a = signed_op ? {{32{opa_q[31]}}, opa_q} : {32'b0, opa_q};
      ext_b = signed_op ? {{32{opb_q[31]}}, opb_q} : {32'b0, opb_q};
      prod  = ext_a * ext_b;
      acc   = {hi_q, lo_q};

      // Shifted remainder needs 33 bits; bit 32 of the difference is the borrow.
      diff    = rq_q[63:31] - {1'b0, opb_q};
      step_rq = diff[32] ? {rq_q[62:0], 1'b0} : {diff[31:0], rq_q[30:0], 1'b1};
      quo_fix = qneg_q ? -rq_q[31:0]  : rq_q[31:0];
      rem_fix = rneg_q ? -rq_q[63:32] : rq_q[63:32];

      case (state_q)
         S_IDLE: begin
            if (start && !flush && legal) begin
               case (op)
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  OP_DIV, OP_DIVU: begin
                     opa_d   = a;
                     opb_d   = (sdiv && b[31]) ? -b : b;
                     rq_d    = {32'b0, (sdiv && a[31]) ? -a : a};
                     qneg_d  = sdiv && (a[31] ^ b[31]);
                     rneg_d  = sdiv && a[31];
                     dz_d    = (b == 32'b0);
                     iter_d  = 5'd0;
                     state_d = S_DIV;
                  end
                  default: begin
                     op_d    = op;
                     opa_d   = a;
                     opb_d   = b;
                     cnt_d   = 4'(MUL_LAT - 1);
                     state_d = S_MUL;
                  end
               endcase
            end
         end
         S_MUL: begin
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
               case (op_q)
                  OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
                  OP_MADD, OP_MADDU: {hi_d, lo_d} = acc + prod;
                  OP_MSUB, OP_MSUBU: {hi_d, lo_d} = acc - prod;
                  default: begin
                     res_d       = prod[31:0];
                     res_valid_d = 1'b1;
                  end
               endcase
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DIV: begin
            rq_d   = step_rq;
            iter_d = iter_q + 5'd1;
            if (iter_q == 5'd31) state_d = S_FIX;
         end
         default: begin  // S_FIX
            if (dz_q) begin
               lo_d = 32'hFFFF_FFFF;
               hi_d = opa_q;
            end else begin
               lo_d = quo_fix;
               hi_d = rem_fix;
            end
            state_d = S_IDLE;
         end
      endcase

      // Flush cancels the op and suppresses any architectural write this cycle.
      if (flush) begin
         state_d     = S_IDLE;
         hi_d        = hi_q;
         lo_d        = lo_q;
         res_d       = res_q;
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         iter_q      <= '0;
         op_q        <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         rq_q        <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         dz_q        <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         iter_q      <= iter_d;
         op_q        <= op_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         rq_q        <= rq_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         dz_q        <= dz_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign stall     = busy && (start || rd_hilo);
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign res       = res_q;
   assign res_valid = res_valid_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the stimulus process pushes the expected
// post-operation HI/LO/res and busy length at each accept; the monitor pops on
// every busy->idle transition and compares.
module tb_muldiv_ctrl;
   localparam int MUL_LAT = 4;
   localparam logic [3:0] MULT = 1, MULTU = 2, DIV = 3, DIVU = 4, MADD = 5,
                          MADDU = 6, MSUB = 7, MSUBU = 8, MTHI = 9, MTLO = 10, MUL = 11;

   logic clk = 1'b0;
   logic rst, start, rd_hilo, flush;
   logic [3:0] op;
   logic [31:0] a, b;
   logic busy, stall, res_valid;
   logic [31:0] hi, lo, res;

   always #5 clk = ~clk;

   muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .rd_hilo(rd_hilo), .flush(flush), .busy(busy), .stall(stall),
      .hi(hi), .lo(lo), .res(res), .res_valid(res_valid)
   );

   typedef struct {
      int          lat;
      logic [31:0] hi, lo, res;
      bit          rv;
   } exp_t;

   exp_t        q[$];
   int          checks = 0, errors = 0;
   logic [31:0] m_hi = 0, m_lo = 0, m_res = 0;
   bit          go = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural effect of one completed op.
   task automatic model_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                           output int lat, output bit rv);
      logic [63:0] ps, pu, acc;
      int sx, sy;
      ps  = longint'($signed(x)) * longint'($signed(y));
      pu  = {32'b0, x} * {32'b0, y};
      acc = {m_hi, m_lo};
      lat = MUL_LAT;
      rv  = 0;
      sx  = x;
      sy  = y;
      case (o)
         MULT:  acc = ps;
         MULTU: acc = pu;
         MADD:  acc = acc + ps;
         MADDU: acc = acc + pu;
         MSUB:  acc = acc - ps;
         MSUBU: acc = acc - pu;
         MUL: begin m_res = ps[31:0]; rv = 1; end
         DIV, DIVU: begin
            lat = 33;
            if (y == 0) acc = {x, 32'hFFFF_FFFF};
            else if (o == DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
               acc = {32'h0, 32'h8000_0000};
            else if (o == DIV) acc = {32'(sx % sy), 32'(sx / sy)};
            else acc = {x % y, x / y};
         end
         MTHI: acc[63:32] = x;
         MTLO: acc[31:0] = x;
         default: ;
      endcase
      {m_hi, m_lo} = acc;
   endtask

   // Monitor: busy cycles are counted; the first idle cycle after them is a completion.
   initial begin
      int   bcnt;
      exp_t e;
      bcnt = 0;
      wait (go);
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            bcnt++;
            chk("res_valid_while_busy", {31'b0, res_valid}, 32'd0);
         end else if (bcnt > 0) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_completion: busy ran %0d cycles, none expected", bcnt);
            end else begin
               e = q.pop_front();
               chk("busy_cycles", 32'(bcnt), 32'(e.lat));
               chk("hi", hi, e.hi);
               chk("lo", lo, e.lo);
               chk("res", res, e.res);
               chk("res_valid", {31'b0, res_valid}, {31'b0, e.rv});
            end
            bcnt = 0;
         end else begin
            chk("res_valid_idle", {31'b0, res_valid}, 32'd0);
         end
      end
   end

   // Called at posedge+1. Holds start until accepted; kill_at>0 cancels the op in
   // that busy cycle with flush (or rst if use_rst).
   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int kill_at = 0, input bit use_rst = 0);
      int   w, lat;
      bit   rv;
      exp_t e;
      start = 1; op = o; a = x; b = y;
      w = 0;
      while (busy !== 1'b0) begin
         chk("stall_held", {31'b0, stall}, 32'd1);
         @(posedge clk); #1;
         if (++w > 200) begin
            checks++; errors++;
            $display("FAIL accept_timeout: busy stuck, op %0d", o);
            start = 0;
            return;
         end
      end
      chk("no_stall_idle", {31'b0, stall}, 32'd0);
      if (kill_at > 0) begin
         if (use_rst) begin m_hi = 0; m_lo = 0; m_res = 0; end
         e.lat = kill_at; e.rv = 0;
      end else begin
         model_op(o, x, y, lat, rv);
         e.lat = lat; e.rv = rv;
      end
      e.hi = m_hi; e.lo = m_lo; e.res = m_res;
      if (o != MTHI && o != MTLO) q.push_back(e);
      @(posedge clk); #1;
      start = 0; op = 0;
      if (o == MTHI || o == MTLO) begin
         chk("mt_hi", hi, m_hi);
         chk("mt_lo", lo, m_lo);
         rd_hilo = 1; #1;
         chk("mfhi_no_stall", {31'b0, stall}, 32'd0);
         rd_hilo = 0;
      end else begin
         chk("accept_busy", {31'b0, busy}, 32'd1);
      end
      if (kill_at > 0) begin
         repeat (kill_at - 1) begin @(posedge clk); #1; end
         if (use_rst) rst = 1; else flush = 1;
         @(posedge clk); #1;
         rst = 0; flush = 0;
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (busy !== 1'b0 || q.size() != 0) begin
         @(posedge clk); #1;
         if (++w > 200) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy=%b pending=%0d", busy, q.size());
            q.delete();
            return;
         end
      end
   endtask

   initial begin
      logic [3:0]  o;
      logic [31:0] x, y;
      int          kill, mode;
      rst = 1; start = 0; op = 0; a = 0; b = 0; rd_hilo = 0; flush = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_res", res, 0);
      chk("rst_res_valid", {31'b0, res_valid}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_stall", {31'b0, stall}, 0);
      go = 1;

      issue(MULT, 32'hFFFF_FFFF, 32'd2);  wait_idle();
      issue(MULTU, 32'hFFFF_FFFF, 32'd2); wait_idle();
      issue(DIV, -32'sd7, 32'd2);         wait_idle();
      issue(DIVU, 32'd100, 32'd7);        wait_idle();
      issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
      issue(DIVU, 32'd5, 32'd0);          wait_idle();
      issue(MTHI, 32'h1234_5678, 32'd0);
      issue(MTLO, 32'd0, 32'd0);
      issue(MADD, 32'd3, 32'd4);          wait_idle();
      chk("madd_hi", hi, 32'h1234_5678);
      chk("madd_lo", lo, 32'd12);
      issue(MSUB, 32'd3, 32'd4);          wait_idle();
      chk("msub_lo", lo, 32'd0);

      // Dependent MULT and MFHI arrive while a divide is in flight.
      issue(DIV, 32'd1000, 32'd3);
      repeat (4) begin @(posedge clk); #1; end
      rd_hilo = 1; #1;
      chk("rd_hilo_stall", {31'b0, stall}, 32'd1);
      rd_hilo = 0;
      issue(MULT, 32'd9, 32'hFFFF_FFF0);  wait_idle();

      issue(DIV, 32'd77, 32'd5, 10);      wait_idle();  // flush mid-divide
      issue(MULTU, 32'd8, 32'd8, 3, 1);   wait_idle();  // reset mid-multiply
      chk("post_rst_res", res, 0);
      issue(MUL, 32'd6, 32'd7);           wait_idle();
      chk("mul_res", res, 32'd42);

      for (int i = 0; i < 60; i++) begin
         o = 4'($urandom_range(1, 11));
         x = $urandom; y = $urandom;
         mode = $urandom_range(0, 7);
         if (mode == 0) y = 0;
         else if (mode == 1) begin x = $urandom_range(0, 300); y = $urandom_range(1, 20); end
         else if (mode == 2) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
         kill = 0;
         if (o != MTHI && o != MTLO && $urandom_range(0, 5) == 0)
            kill = $urandom_range(1, (o == DIV || o == DIVU) ? 33 : MUL_LAT);
         issue(o, x, y, kill);
         if ($urandom_range(0, 2) != 0) wait_idle();
      end
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
